// File: rtl/tfe_timer_pkg.sv
// Shared definitions for the TFE timer scheduler: time-base width, delay ceiling,
// per-channel state encoding and the wrap-safe deadline compare.
package tfe_timer_pkg;

  localparam int unsigned TIME_W = 34;
  localparam logic [TIME_W-1:0] MAX_DELAY = {1'b0, {(TIME_W-1){1'b1}}};

  typedef enum logic {
    StIdle  = 1'b0,
    StArmed = 1'b1
  } ch_state_e;

  // True once `now` has reached `deadline`, valid while the two are within half the time range.
  function automatic logic time_reached(input logic [63:0]   now,
                                        input logic [63:0]   deadline,
                                        input int unsigned   width);
    logic [63:0] diff;
    diff = now - deadline;
    return ~diff[6'(width - 1)];
  endfunction

endpackage

// File: rtl/tfe_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer, which moves
// past the granted requester whenever the grant is taken.
module tfe_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_req,
  input  logic            i_advance,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_gnt_idx
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_ptr_nxt;
  logic [IdxW-1:0] w_cand;
  logic            w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IdxW'((32'(r_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_gnt_idx     = w_cand;
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_advance && w_found) begin
      w_ptr_nxt = (o_gnt_idx == IdxW'(N - 1)) ? '0 : o_gnt_idx + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/tfe_timer_sched.sv
// Multi-channel alarm scheduler: arms relative timeouts as absolute deadlines on the
// shared time base and pulses o_expire per channel when a deadline is reached.
module tfe_timer_sched #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned TIME_W = tfe_timer_pkg::TIME_W,
  parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TIME_W-1:0]        i_time,
  input  logic [NUM_CH-1:0]        i_req_valid,
  input  logic [NUM_CH*TIME_W-1:0] i_req_delay,
  output logic [NUM_CH-1:0]        o_req_ready,
  input  logic [NUM_CH-1:0]        i_cancel,
  output logic [NUM_CH-1:0]        o_armed,
  output logic [NUM_CH-1:0]        o_expire,
  output logic [IDX_W-1:0]         o_grant_idx
);
  import tfe_timer_pkg::*;

  localparam logic [TIME_W-1:0] MaxDelay = {1'b0, {(TIME_W-1){1'b1}}};

  logic [NUM_CH-1:0] w_cand;
  logic [NUM_CH-1:0] w_gnt;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [IDX_W-1:0]  r_grant_idx;

  // A channel being cancelled this cycle is not a candidate for arming.
  assign w_cand      = i_req_valid & ~i_cancel;
  assign o_req_ready = w_gnt;
  assign o_grant_idx = r_grant_idx;

  tfe_rr_arbiter #(
    .N    (NUM_CH),
    .IdxW (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_cand),
    .i_advance (|w_gnt),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_idx <= '0;
    end else if (|w_gnt) begin
      r_grant_idx <= w_gnt_idx;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_e         r_state;
    ch_state_e         w_state_nxt;
    logic [TIME_W-1:0] r_deadline;
    logic [TIME_W-1:0] w_deadline_nxt;
    logic [TIME_W-1:0] w_delay;
    logic [TIME_W-1:0] w_delay_sat;
    logic              r_expire;
    logic              w_expire_nxt;
    logic              w_reached;

    assign w_delay     = i_req_delay[gi*TIME_W +: TIME_W];
    assign w_delay_sat = w_delay[TIME_W-1] ? MaxDelay : w_delay;
    assign w_reached   = time_reached(64'(i_time), 64'(r_deadline), TIME_W);

    // Cancel beats arm beats expiry; a re-arm in the expiry cycle swallows the pulse.
    always_comb begin
      w_state_nxt    = r_state;
      w_deadline_nxt = r_deadline;
      w_expire_nxt   = 1'b0;
      if (i_cancel[gi]) begin
        w_state_nxt = StIdle;
      end else if (w_gnt[gi]) begin
        w_state_nxt    = StArmed;
        w_deadline_nxt = i_time + w_delay_sat;
      end else if (r_state == StArmed && w_reached) begin
        w_state_nxt  = StIdle;
        w_expire_nxt = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= StIdle;
        r_deadline <= '0;
        r_expire   <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_deadline <= w_deadline_nxt;
        r_expire   <= w_expire_nxt;
      end
    end

    assign o_armed[gi]  = (r_state == StArmed);
    assign o_expire[gi] = r_expire;
  end

endmodule
